// File: rtl/mem_arbiter.sv
// Arbiter for the shared single-port program/data RAM: the CPU core normally owns it,
// while a starvation counter guarantees the DMA/loader port bounded-latency bursts.
module mem_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MAX_WAIT  = 4,
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic              dma_last,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_DMA  = 2'd2;

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int BEAT_W = $clog2(BURST_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_TOP  = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_MAX - 1);
  localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);

  logic [1:0]        owner;
  logic [1:0]        next_owner;
  logic [WAIT_W-1:0] wait_cnt;
  logic [BEAT_W-1:0] beat_cnt;
  logic              cpu_beat;
  logic              dma_beat;
  logic              starve;
  logic              dma_release;

  assign cpu_beat    = (owner == OWN_CPU) && cpu_req;
  assign dma_beat    = (owner == OWN_DMA) && dma_req;
  assign starve      = dma_req && (wait_cnt == WAIT_TOP);
  assign dma_release = !dma_req || (dma_beat && dma_last) || (dma_beat && (beat_cnt == BEAT_LAST));

  assign cpu_stall = cpu_req && (owner != OWN_CPU);
  assign dma_gnt   = (owner == OWN_DMA);
  assign rdata     = ram_rdata;

  // Next-owner decision; a releasing DMA can only hand over to the CPU or to idle.
  always_comb begin
    next_owner = OWN_NONE;
    case (owner)
      OWN_NONE, OWN_CPU: begin
        if (starve) begin
          next_owner = OWN_DMA;
        end else if (cpu_req) begin
          next_owner = OWN_CPU;
        end else if (dma_req) begin
          next_owner = OWN_DMA;
        end else begin
          next_owner = OWN_NONE;
        end
      end
      OWN_DMA: begin
        if (!dma_release) begin
          next_owner = OWN_DMA;
        end else if (cpu_req) begin
          next_owner = OWN_CPU;
        end else begin
          next_owner = OWN_NONE;
        end
      end
      default: next_owner = OWN_NONE;
    endcase
  end

  // RAM port steering from the current owner; idle drives all zeros.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (owner)
      OWN_CPU: begin
        ram_we    = cpu_beat && cpu_we;
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
      end
      OWN_DMA: begin
        ram_we    = dma_beat && dma_we;
        ram_addr  = dma_addr;
        ram_wdata = dma_wdata;
      end
      default: begin
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
      end
    endcase
  end

  // Ownership and one-cycle read-return flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner      <= OWN_NONE;
      cpu_rvalid <= 1'b0;
      dma_rvalid <= 1'b0;
    end else begin
      owner      <= next_owner;
      cpu_rvalid <= cpu_beat && !cpu_we;
      dma_rvalid <= dma_beat && !dma_we;
    end
  end

  // Starvation counter: counts denied DMA cycles, saturating so starve stays asserted.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (!dma_req || (next_owner == OWN_DMA)) begin
      wait_cnt <= '0;
    end else if ((owner != OWN_DMA) && (wait_cnt != WAIT_TOP)) begin
      wait_cnt <= wait_cnt + WAIT_ONE;
    end else begin
      wait_cnt <= wait_cnt;
    end
  end

  // Burst beat counter, restarted on every ownership change.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt <= '0;
    end else if (next_owner != owner) begin
      beat_cnt <= '0;
    end else if (dma_beat) begin
      beat_cnt <= beat_cnt + BEAT_ONE;
    end else begin
      beat_cnt <= beat_cnt;
    end
  end

endmodule
